// File: rtl/skid_reg_stage.sv
// skid_reg_stage: elastic two-entry valid/ready stage that registers both the data and the ready path.
// Optional saturating stall counter on STALL_CNT when SKID_REG_STAGE_STALL_CNT_EN is defined.
module skid_reg_stage #(
    parameter int WIDTH  = 18,
    parameter int SELECT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CEN,
    input  logic [WIDTH-1:0] S_DATA,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic [WIDTH-1:0] M_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [1:0]       OCC
`ifdef SKID_REG_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]      STALL_CNT
`endif
);

    logic w_m_valid;
    logic w_s_ready;

    assign M_VALID = w_m_valid;
    assign S_READY = w_s_ready;

    generate
        if (SELECT == 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = CLK ^ RST;
            assign M_DATA    = S_DATA;
            assign w_m_valid = S_VALID & CEN;
            assign w_s_ready = M_READY & CEN;
            assign OCC       = 2'd0;
        end else begin : g_skid
            // State encoding equals occupancy so OCC is taken straight from the state flops.
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_ONE   = 2'd1;
            localparam logic [1:0] ST_FULL  = 2'd2;

            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic [WIDTH-1:0] w_main_nxt;
            logic [WIDTH-1:0] w_skid_nxt;
            logic             r_ready_q;
            logic             w_s_fire;
            logic             w_m_fire;

            assign w_m_valid = CEN & (r_state != ST_EMPTY);
            assign w_s_ready = CEN & r_ready_q & (r_state != ST_FULL);
            assign w_s_fire  = S_VALID & w_s_ready;
            assign w_m_fire  = w_m_valid & M_READY;
            assign M_DATA    = r_main;
            assign OCC       = r_state;

            // Next-state and datapath selection; both fires are zero while CEN is low, so everything holds.
            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_s_fire) begin
                            w_main_nxt  = S_DATA;
                            w_state_nxt = ST_ONE;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                    ST_ONE: begin
                        if (w_s_fire && w_m_fire) begin
                            w_main_nxt  = S_DATA;
                            w_state_nxt = ST_ONE;
                        end else if (w_s_fire) begin
                            w_skid_nxt  = S_DATA;
                            w_state_nxt = ST_FULL;
                        end else if (w_m_fire) begin
                            w_state_nxt = ST_EMPTY;
                        end else begin
                            w_state_nxt = ST_ONE;
                        end
                    end
                    ST_FULL: begin
                        if (w_m_fire) begin
                            w_main_nxt  = r_skid;
                            w_state_nxt = ST_ONE;
                        end else begin
                            w_state_nxt = ST_FULL;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_EMPTY;
                    end
                endcase
            end

            // State, data registers and the post-reset ready flag.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_state   <= ST_EMPTY;
                    r_main    <= {WIDTH{1'b0}};
                    r_skid    <= {WIDTH{1'b0}};
                    r_ready_q <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_main    <= w_main_nxt;
                    r_skid    <= w_skid_nxt;
                    r_ready_q <= r_ready_q | CEN;
                end
            end
        end
    endgenerate

`ifdef SKID_REG_STAGE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where a valid word waits on the downstream.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stall_cnt <= 16'd0;
        end else if (w_m_valid && !M_READY && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: doc/skid_reg_stage.md
# skid_reg_stage

Elastic two-entry pipeline stage carrying a WIDTH-bit operand between DSP slice sections under valid/ready flow control. Where a fixed register/bypass pair only retimes the forward data path, this block also retimes the backward (ready) path, so a downstream stall never creates a combinational path back to the upstream producer. With SELECT=1 it registers both directions at full throughput. With SELECT=0 it is a wire-through with CEN gating.

## Interface
- WIDTH, 18: data width in bits.
- SELECT, 1: 0 = no storage (bypass); 1 = registered skid stage.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- CEN  input  1  clock enable; when low, no transfer occurs on either side.
- S_DATA  input  WIDTH  upstream data.
- S_VALID  input  1  upstream data valid.
- S_READY  output  1  stage can accept S_DATA.
- M_DATA  output  WIDTH  downstream data.
- M_VALID  output  1  M_DATA valid.
- M_READY  input  1  downstream accepts.
- OCC  output  2  stored words: 0, 1 or 2.

## Operation
- Upstream fire (s_fire) = S_VALID & S_READY. Downstream fire (m_fire) = M_VALID & M_READY. S_READY and M_VALID are already gated by CEN.
- **SELECT=0:**
  - M_DATA = S_DATA.
  - M_VALID = S_VALID & CEN.
  - S_READY = M_READY & CEN.
  - OCC = 0.
  - No registers except the optional counter.
- **SELECT=1:** uses a main register (drives M_DATA), a skid register, and a state machine.
  - States: EMPTY (OCC=0), ONE (OCC=1), FULL (OCC=2).
  - M_VALID = CEN & (state != EMPTY).
  - S_READY = CEN & ready_q & (state != FULL). ready_q is 0 in reset and is set on the first CLK edge after RST deasserts.
  - EMPTY, s_fire: main <= S_DATA, go to ONE.
  - ONE, s_fire only: skid <= S_DATA, go to FULL.
  - ONE, m_fire only: go to EMPTY.
  - ONE, both fire: main <= S_DATA, stay in ONE.
  - FULL, m_fire: main <= skid, go to ONE. S_READY is 0 in FULL, so no input is accepted.
  - CEN=0: state, main, skid and ready_q all hold. Nothing is lost or duplicated.
- Data order is strictly FIFO; the skid word is always older than any new input.
- **Reset (RST=0, async):**
  - State EMPTY; main and skid = 0.
  - M_DATA = 0, M_VALID = 0, S_READY = 0, OCC = 0, ready_q = 0.
- Reset asserted mid-operation discards stored words. No transfer is reported in that cycle.

## Timing
- SELECT=1:
  - Latency is 1 cycle: a word accepted at edge k appears on M_DATA/M_VALID after edge k.
  - Throughput is 1 word/cycle in steady state when M_READY=1.
  - M_DATA, OCC and the state-derived parts of M_VALID/S_READY come straight from flops.
  - The only combinational input-to-output paths are CEN -> M_VALID and CEN -> S_READY. There is no path from M_READY to S_READY or from S_DATA to M_DATA.
  - A downstream stall is absorbed by the skid register. S_READY falls one cycle after the stall first meets a full pipeline, i.e. once the stage reaches FULL.
- SELECT=0: zero latency, fully combinational.

## Configuration
- Macro: SKID_REG_STAGE_STALL_CNT_EN.
- **Defined:**
  - Adds output STALL_CNT (16 bits), a count of cycles with M_VALID=1 and M_READY=0.
  - Saturates at 16'hFFFF.
  - Resets to 0 on RST.
  - Holds while CEN=0, since M_VALID is 0 then.
- **Undefined:** port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then stream: RST low with S_VALID=1 gives S_READY=0, M_VALID=0, OCC=0. After release, S_READY=1 from the second edge. Values 1,2,3 with M_READY=1 appear on M_DATA one cycle after each is accepted, OCC=1 throughout.
- Backpressure: stream 10,11,12,13 and hold M_READY=0 after 10 is in main. 11 enters skid, OCC=2 and S_READY=0. 12 holds on the S side. Releasing M_READY yields 10,11,12,13 in order with no gaps after the first.
- CEN stall: in FULL state, drop CEN for 3 cycles with M_READY=1. M_VALID=0 and S_READY=0, OCC stays 2, contents unchanged. Draining after CEN=1 gives the same words.
- Async reset mid-flight: state FULL, pulse RST low between edges. Outputs go to 0 immediately. After release, no stale word appears.
- SELECT=0: S_DATA=0x2A, S_VALID=1, M_READY=0, CEN=1 gives M_DATA=0x2A, M_VALID=1, S_READY=0. Setting CEN=0 forces M_VALID=0 and S_READY=0.
- With SKID_REG_STAGE_STALL_CNT_EN defined: 5 stalled cycles give STALL_CNT=5. A forced long stall stops at 0xFFFF.
